// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants: opcodes, functs, mnemonic codes and field positions.
// Used by both the instruction encoder and the control decoder.
package instr_pkg;

  typedef enum logic [3:0] {
    MN_LW    = 4'd0,
    MN_SW    = 4'd1,
    MN_J     = 4'd2,
    MN_JAL   = 4'd3,
    MN_BEQ   = 4'd4,
    MN_BNE   = 4'd5,
    MN_XORI  = 4'd6,
    MN_ADDI  = 4'd7,
    MN_ADDIU = 4'd8,
    MN_JR    = 4'd9,
    MN_ADD   = 4'd10,
    MN_SUB   = 4'd11,
    MN_SLT   = 4'd12,
    MN_XOR   = 4'd13
  } mnem_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } enc_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_XOR = 6'b100110;

  // Least-significant bit of each instruction field
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FN_LSB    = 0;
  localparam int IMM_LSB   = 0;
  localparam int TGT_LSB   = 0;

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor-in / instruction-word-out streams of the encoder.
// Both streams transfer on a clock edge where valid && ready; a producer holds its payload until then.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
) ();
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, in_last, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, in_last, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_fifo2.sv
// Two-entry FIFO, no bypass: a pushed entry is visible on dout_o the cycle after the push.
module instr_fifo2 #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: symbolic descriptors in, addressed 32-bit words out.
// Build option ENC_XOR_EN makes mnemonic code 13 encode the R-type XOR instead of being illegal.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [CNT_W-1:0]  instr_count,
  output enc_state_t        state_o
);

  enc_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;
  logic              err_q;

  logic [31:0]       word_d;
  logic              legal_d;
  logic              accept;
  logic              push;
  logic              pop;
  logic [ADDR_W+31:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_cnt;

  function automatic logic [31:0] pack_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6]   = op;
    w[RS_LSB +: 5]   = rs;
    w[RT_LSB +: 5]   = rt;
    w[IMM_LSB +: 16] = imm;
    return w;
  endfunction

  function automatic logic [31:0] pack_j(logic [5:0] op, logic [25:0] target);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6]   = op;
    w[TGT_LSB +: 26] = target;
    return w;
  endfunction

  function automatic logic [31:0] pack_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [5:0] funct);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6]    = OP_RTYPE;
    w[RS_LSB +: 5]    = rs;
    w[RT_LSB +: 5]    = rt;
    w[RD_LSB +: 5]    = rd;
    w[SHAMT_LSB +: 5] = 5'd0;
    w[FN_LSB +: 6]    = funct;
    return w;
  endfunction

  always_comb begin
    word_d  = '0;
    legal_d = 1'b1;
    case (bus.in_mnem)
      MN_LW:    word_d = pack_i(OP_LW,    bus.in_rs, bus.in_rt, bus.in_imm);
      MN_SW:    word_d = pack_i(OP_SW,    bus.in_rs, bus.in_rt, bus.in_imm);
      MN_J:     word_d = pack_j(OP_J,     bus.in_target);
      MN_JAL:   word_d = pack_j(OP_JAL,   bus.in_target);
      MN_BEQ:   word_d = pack_i(OP_BEQ,   bus.in_rs, bus.in_rt, bus.in_imm);
      MN_BNE:   word_d = pack_i(OP_BNE,   bus.in_rs, bus.in_rt, bus.in_imm);
      MN_XORI:  word_d = pack_i(OP_XORI,  bus.in_rs, bus.in_rt, bus.in_imm);
      MN_ADDI:  word_d = pack_i(OP_ADDI,  bus.in_rs, bus.in_rt, bus.in_imm);
      MN_ADDIU: word_d = pack_i(OP_ADDIU, bus.in_rs, bus.in_rt, bus.in_imm);
      // JR only names its source register; rt and rd are forced to zero
      MN_JR:    word_d = pack_r(bus.in_rs, 5'd0, 5'd0, FN_JR);
      MN_ADD:   word_d = pack_r(bus.in_rs, bus.in_rt, bus.in_rd, FN_ADD);
      MN_SUB:   word_d = pack_r(bus.in_rs, bus.in_rt, bus.in_rd, FN_SUB);
      MN_SLT:   word_d = pack_r(bus.in_rs, bus.in_rt, bus.in_rd, FN_SLT);
`ifdef ENC_XOR_EN
      MN_XOR:   word_d = pack_r(bus.in_rs, bus.in_rt, bus.in_rd, FN_XOR);
`endif
      default:  legal_d = 1'b0;
    endcase
  end

  assign bus.in_ready = (state_q == ST_RUN) && !fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && legal_d;
  assign pop          = bus.out_valid && bus.out_ready;

  instr_fifo2 #(.W(ADDR_W + 32)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   ({addr_q, word_d}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= accept && !legal_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= base_addr;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            // Illegal descriptors are consumed without using an address slot
            if (legal_d) begin
              addr_q <= addr_q + ADDR_W'(1);
              if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
            if (bus.in_last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_cnt == 2'd0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = !fifo_empty;
  assign bus.out_instr = fifo_dout[31:0];
  assign bus.out_addr  = fifo_dout[ADDR_W+31:32];
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err_illegal   = err_q;
  assign instr_count   = cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed loads plus randomized descriptors and backpressure,
// checked by a scoreboard fed from an arithmetic model of the MIPS encodings.
module tb_instr_encoder;
  import instr_pkg::*;

  localparam int AW = 10;
  localparam int CW = 16;
  localparam int W  = 32 + AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy;
  logic          done;
  logic          err_illegal;
  logic [CW-1:0] instr_count;
  enc_state_t    dbg_state;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal),
    .instr_count (instr_count),
    .state_o     (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  int model_addr = 0;
  int model_cnt = 0;
  int err_exp = 0;
  int err_seen = 0;
  int done_exp = 0;
  int done_seen = 0;
  bit rnd_stop = 1'b0;

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding from the instruction formats, built with plain arithmetic
  function automatic void ref_model(input int mn, input int rs, input int rt, input int rd,
                                    input int imm, input int tgt,
                                    output bit legal, output longint unsigned word);
    longint unsigned op;
    longint unsigned fn;
    int kind;  // 0 I-type, 1 J-type, 2 R-type, 3 JR
    legal = 1'b1;
    op = 0;
    fn = 0;
    kind = 0;
    case (mn)
      0:  op = 'b100011;
      1:  op = 'b101011;
      2:  begin op = 'b000010; kind = 1; end
      3:  begin op = 'b000011; kind = 1; end
      4:  op = 'b000100;
      5:  op = 'b000101;
      6:  op = 'b001110;
      7:  op = 'b001000;
      8:  op = 'b001001;
      9:  begin fn = 'b001000; kind = 3; end
      10: begin fn = 'b100000; kind = 2; end
      11: begin fn = 'b100010; kind = 2; end
      12: begin fn = 'b101010; kind = 2; end
`ifdef ENC_XOR_EN
      13: begin fn = 'b100110; kind = 2; end
`endif
      default: legal = 1'b0;
    endcase
    case (kind)
      0: word = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
      1: word = op * 64'd67108864 + tgt;
      2: word = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + fn;
      default: word = rs * 64'd2097152 + fn;
    endcase
    if (!legal) word = 0;
  endfunction

  // Scoreboard monitor: pops on every output transfer and checks hold under backpressure
  bit hold_pend = 1'b0;
  logic [W-1:0] hold_word = '0;
  always @(negedge clk) begin
    logic [W-1:0] cur;
    logic [W-1:0] exp;
    cur = {bus.out_addr, bus.out_instr};
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (done) done_seen++;
      if (err_illegal) err_seen++;
      if (hold_pend) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_word", cur, hold_word);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got addr 0x%0h instr 0x%0h want no word",
                   bus.out_addr, bus.out_instr);
        end else begin
          exp = exp_q.pop_front();
          chk("out_addr", bus.out_addr, exp[W-1:32]);
          chk("out_instr", bus.out_instr, exp[31:0]);
        end
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_word = cur;
    end
  end

  task automatic start_load(input int base);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(base);
    @(posedge clk); #1;
    start = 1'b0;
    model_addr = base;
    model_cnt = 0;
  endtask

  task automatic send(input int mn, input int rs, input int rt, input int rd,
                      input int imm, input int tgt, input bit last);
    bit lg;
    longint unsigned w;
    logic [W-1:0] e;
    int n;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_mnem   = 4'(mn);
    bus.in_rs     = 5'(rs);
    bus.in_rt     = 5'(rt);
    bus.in_rd     = 5'(rd);
    bus.in_imm    = 16'(imm);
    bus.in_target = 26'(tgt);
    bus.in_last   = last;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles want 1", n);
      bus.in_valid = 1'b0;
      return;
    end
    ref_model(mn, rs, rt, rd, imm, tgt, lg, w);
    if (lg) begin
      e = {AW'(model_addr), 32'(w)};
      exp_q.push_back(e);
      model_addr = (model_addr + 1) % (1 << AW);
      if (model_cnt < (1 << CW) - 1) model_cnt++;
    end else begin
      err_exp++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_done_timeout: done=0 after %0d cycles want pulse", tag, n);
    end else begin
      done_exp++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_count"}, instr_count, model_cnt);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_pulses"}, done_seen, done_exp);
    chk({tag, "_err_pulses"}, err_seen, err_exp);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_mnem = '0;
    bus.in_rs = '0;
    bus.in_rt = '0;
    bus.in_rd = '0;
    bus.in_imm = '0;
    bus.in_target = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 0);

    // Single ADDI program
    start_load('h010);
    @(negedge clk);
    chk("run_busy", busy, 1);
    send(7, 1, 2, 0, 'h0005, 0, 1'b1);
    wait_done("addi");

    // Mixed R/I/J-type program
    start_load('h120);
    send(10, 1, 2, 3, 0, 0, 1'b0);
    send(0, 29, 8, 0, 4, 0, 1'b0);
    send(2, 0, 0, 0, 0, 'h0000010, 1'b0);
    send(9, 31, 7, 9, 'h1234, 0, 1'b1);
    wait_done("mixed");

    // Backpressure: third descriptor stalls until the consumer resumes
    start_load('h200);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(8, 3, 4, 0, 'h7fff, 0, 1'b0);
    send(1, 5, 6, 0, 'h0010, 0, 1'b0);
    @(negedge clk);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    fork
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      send(12, 7, 8, 9, 0, 0, 1'b1);
    join
    wait_done("bp");

    // Illegal mnemonic between two legal words
    start_load('h300);
    send(5, 4, 5, 0, 'hffff, 0, 1'b0);
    send(14, 1, 1, 1, 'h1111, 'h1111, 1'b0);
    send(11, 6, 7, 8, 0, 0, 1'b1);
    wait_done("illegal");

    // Illegal final descriptor still ends the load
    start_load('h040);
    send(3, 0, 0, 0, 0, 'h3ffffff, 1'b0);
    send(15, 0, 0, 0, 0, 0, 1'b1);
    wait_done("illegal_last");

    // Address wrap
    start_load('h3ff);
    send(4, 2, 3, 0, 'h8000, 0, 1'b0);
    send(6, 9, 10, 0, 'h00ff, 0, 1'b1);
    wait_done("wrap");

    // Randomized descriptors with random consumer stalls
    start_load(int'($urandom_range(0, (1 << AW) - 1)));
    rnd_stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, (1 << 26) - 1)),
               (i == 59));
        end
        rnd_stop = 1'b1;
      end
      begin
        while (!rnd_stop) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_done("random");

    // Reset in the middle of DRAIN discards the FIFO and produces no done
    start_load('h155);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(7, 1, 1, 0, 1, 0, 1'b0);
    send(7, 2, 2, 0, 2, 0, 1'b1);
    @(negedge clk);
    chk("drain_busy", busy, 1);
    chk("drain_state", dbg_state, ST_DRAIN);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_instr", bus.out_instr, 0);
    chk("mid_rst_out_addr", bus.out_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", instr_count, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_done_pulses", done_seen, done_exp);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_state", dbg_state, ST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming MIPS instruction encoder. It is the inverse of the control decoder.
- Accepts symbolic instruction descriptors (mnemonic plus register, immediate and target fields) over a valid/ready handshake.
- Emits packed 32-bit instruction words, each with a sequential instruction-memory word address, through a 2-entry output buffer.
- Used by the test/boot loader path to fill instruction memory before the CPU runs.

Parameters:
- ADDR_W, 10, width of the instruction-memory word address; wraps modulo 2^ADDR_W.
- CNT_W, 16, width of the emitted-instruction counter; saturates.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a program load at base_addr
- base_addr  in  ADDR_W  first word address, sampled on start
- in_valid  in  1  descriptor valid
- in_ready  out  1  encoder can accept a descriptor
- in_mnem  in  4  mnemonic code (see Behaviour)
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target field
- in_last  in  1  marks final descriptor of the program
- out_valid  out  1  out_instr/out_addr valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address for out_instr
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse on DRAIN->IDLE
- err_illegal  out  1  one-cycle pulse, cycle after an illegal mnemonic is accepted
- instr_count  out  CNT_W  words pushed since last start; saturating

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_instr=0, out_addr=0, busy=0, done=0, err_illegal=0, instr_count=0. FSM goes to IDLE, FIFO empties, address counter=0.
- Mnemonic codes (4-bit enum):
  - 0 LW, op 100011
  - 1 SW, op 101011
  - 2 J, op 000010
  - 3 JAL, op 000011
  - 4 BEQ, op 000100
  - 5 BNE, op 000101
  - 6 XORI, op 001110
  - 7 ADDI, op 001000
  - 8 ADDIU, op 001001
  - 9 JR, funct 001000
  - 10 ADD, funct 100000
  - 11 SUB, funct 100010
  - 12 SLT, funct 101010
  - 13-15 illegal, unless the optional feature is enabled
- Packing:
  - I-type {op,rs,rt,imm}
  - J-type {op,target}
  - R-type {000000,rs,rt,rd,5'b0,funct}
  - JR forces rt=rd=0.
  - Unused fields are ignored, never packed.
- Handshake: a transfer occurs when in_valid&&in_ready. in_ready = (state==RUN) && FIFO count<2. A legal word is written into the FIFO at the accepting edge, so it is visible on out_* the next cycle: latency 1. Output pops when out_valid&&out_ready. A push and a pop in the same cycle leave count unchanged. out_* hold stable while out_valid&&!out_ready.
- Address: each legal push gets the current counter value, then the counter increments. 2^ADDR_W-1 wraps to 0.
- FSM:
  - IDLE: a start pulse loads the address counter with base_addr, clears instr_count, and moves to RUN.
  - RUN: an accepted descriptor with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty, move to IDLE and pulse done.
  - start in RUN or DRAIN is ignored.
- Illegal mnemonic:
  - The descriptor is consumed, but nothing is pushed and the address does not advance.
  - err_illegal pulses.
  - in_last on an illegal descriptor still moves the FSM to DRAIN.
- Asynchronous reset mid-load discards the FIFO contents with no done pulse.

Optional Feature:
- Macro ENC_XOR_EN.
- Defined: code 13 = XOR R-type, funct 100110. It is encoded like ADD.
- Undefined: code 13 is illegal.

Decomposition:
- Shared package instr_pkg holds:
  - opcode and funct constants
  - the mnemonic enum typedef
  - the I/J/R field-position constants
- The decoder uses the same package.
- One sub-module, instr_fifo2: a 2-entry FIFO with push/pop, full/empty and count; no bypass.
- Packing logic is purely combinational inside the top.

Test Plan:
- start base_addr=0x010, then ADDI rs=1 rt=2 imm=0x0005 with in_last -> out_instr=0x20220005, out_addr=0x010, then done pulse; instr_count=1.
- ADD rs=1 rt=2 rd=3 then LW rs=29 rt=8 imm=4 -> 0x00221820 at addr A, then 0x8FA80004 at addr A+1.
- J target=0x0000010; JR rs=31 rt=7 rd=9 -> 0x08000010; 0x03E00008 (rt/rd ignored).
- Backpressure: out_ready=0, send 3 words -> in_ready drops after 2 pushes; out_* stable; releasing out_ready drains the words in order.
- in_mnem=14 between BNE rs=4 rt=5 imm=0xFFFF and SUB -> 0x1485FFFF then the SUB word at consecutive addresses; err_illegal pulses once.
- base_addr=0x3FF with 2 words -> addresses 0x3FF, 0x000; rst_n low mid-DRAIN -> all outputs at reset values, no done.
